// File: rtl/data_memory_bank.sv
// data_memory_bank: CPU data memory with a valid/ready request port and a
// one-cycle-latency registered response. A hardware init walker rewrites every
// word after Reset or Clear (two preset addresses get their own values), so the
// storage array carries no reset and can map onto block RAM.
module data_memory_bank #(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 5,
    parameter int                DEPTH        = 32,
    parameter logic [DATA_W-1:0] FILL_VAL     = 8'h00,
    parameter logic [ADDR_W-1:0] PRESET0_ADDR = 5'h1B,
    parameter logic [DATA_W-1:0] PRESET0_VAL  = 8'hFF,
    parameter logic [ADDR_W-1:0] PRESET1_ADDR = 5'h1C,
    parameter logic [DATA_W-1:0] PRESET1_VAL  = 8'hAA
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_we,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [DATA_W-1:0] Req_wdata,
    output logic              Rsp_valid,
    output logic [DATA_W-1:0] Rsp_rdata,
    output logic              Addr_err,
    output logic              Init_done
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Pointer is one bit wider than the address so DEPTH = 2**ADDR_W ends cleanly.
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   init_ptr;
    logic [ADDR_W:0]   init_ptr_nxt;
    logic [ADDR_W-1:0] init_idx;
    logic [DATA_W-1:0] init_val;
    logic              accept;
    logic              in_range;

    // Request captured at the accept edge; the response is formed one edge later.
    logic              pend_valid;
    logic              pend_we;
    logic              pend_err;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;

    assign init_idx  = init_ptr[ADDR_W-1:0];
    assign in_range  = ({1'b0, Req_addr} < DEPTH_W);
    assign Init_done = (state == ST_READY);
    // Clear and Reset both outrank a request, so they withdraw ready combinationally.
    assign Req_ready = (state == ST_READY) && !Clear && !Reset;
    assign accept    = Req_valid && Req_ready;

    // State register and init walk pointer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            state    <= state_nxt;
            init_ptr <= init_ptr_nxt;
        end
    end

    // Next-state logic: walk every word once, then serve requests until Clear.
    always_comb begin
        state_nxt    = state;
        init_ptr_nxt = init_ptr;
        case (state)
            ST_INIT: begin
                init_ptr_nxt = init_ptr + 1'b1;
                if (init_ptr == LAST_PTR) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (Clear) begin
                    state_nxt    = ST_INIT;
                    init_ptr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = ST_INIT;
                init_ptr_nxt = '0;
            end
        endcase
    end

    // Init value for the current walk position; PRESET0 takes precedence.
    always_comb begin
        init_val = FILL_VAL;
        if (init_idx == PRESET0_ADDR) begin
            init_val = PRESET0_VAL;
        end else if (init_idx == PRESET1_ADDR) begin
            init_val = PRESET1_VAL;
        end
    end

    // Single write port shared by the init walker and accepted in-range writes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == ST_INIT) begin
                mem[init_idx] <= init_val;
            end else if (accept && Req_we && in_range) begin
                mem[Req_addr] <= Req_wdata;
            end
        end
    end

    // Capture the accepted request; a reset drops anything pending.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= accept;
            if (accept) begin
                pend_we    <= Req_we;
                pend_err   <= !in_range;
                pend_addr  <= Req_addr;
                pend_wdata <= Req_wdata;
            end
        end
    end

    // Response register: read data, write echo, or zero for an out-of-range address.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Rsp_valid <= 1'b0;
            Addr_err  <= 1'b0;
            Rsp_rdata <= '0;
        end else begin
            Rsp_valid <= pend_valid;
            Addr_err  <= pend_valid && pend_err;
            if (pend_valid) begin
                if (pend_err) begin
                    Rsp_rdata <= '0;
                end else if (pend_we) begin
                    Rsp_rdata <= pend_wdata;
                end else begin
                    Rsp_rdata <= mem[pend_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: randomized and directed checks of data_memory_bank
// against a behavioural memory model, on a default instance and a DEPTH=20 one.
module tb_data_memory_bank;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, rv, we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       rdy, rsp_v, aerr, idone;
    logic [7:0] rsp_d;

    logic       rst_b, clr_b, rv_b, we_b;
    logic [4:0] addr_b;
    logic [7:0] wdata_b;
    logic       rdy_b, rsp_v_b, aerr_b, idone_b;
    logic [7:0] rsp_d_b;

    data_memory_bank dut (
        .Clk(clk), .Reset(rst), .Clear(clr), .Req_valid(rv), .Req_ready(rdy),
        .Req_we(we), .Req_addr(addr), .Req_wdata(wdata), .Rsp_valid(rsp_v),
        .Rsp_rdata(rsp_d), .Addr_err(aerr), .Init_done(idone)
    );

    data_memory_bank #(.DEPTH(20)) dut_b (
        .Clk(clk), .Reset(rst_b), .Clear(clr_b), .Req_valid(rv_b), .Req_ready(rdy_b),
        .Req_we(we_b), .Req_addr(addr_b), .Req_wdata(wdata_b), .Rsp_valid(rsp_v_b),
        .Rsp_rdata(rsp_d_b), .Addr_err(aerr_b), .Init_done(idone_b)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] model   [32];
    logic [7:0] model_b [20];
    logic [7:0] hold_a = 8'h00;
    logic [7:0] hold_b = 8'h00;

    // Contents after a completed init walk of the default instance.
    function automatic void model_init_a();
        for (int i = 0; i < 32; i++) model[i] = 8'h00;
        model[28] = 8'hAA;
        model[27] = 8'hFF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; rv = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        rst_b = 1'b1; clr_b = 1'b0; rv_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        step();
        rst = 1'b0; rst_b = 1'b0;
        checks++;
        if (rdy !== 1'b0 || rsp_v !== 1'b0 || aerr !== 1'b0 || idone !== 1'b0 || rsp_d !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: rdy=%b rsp_v=%b aerr=%b idone=%b rdata=%h expected 0 0 0 0 00",
                     rdy, rsp_v, aerr, idone, rsp_d);
        end
        checks++;
        if (rdy_b !== 1'b0 || rsp_v_b !== 1'b0 || idone_b !== 1'b0 || rsp_d_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_state_b: rdy=%b rsp_v=%b idone=%b rdata=%h expected 0 0 0 00",
                     rdy_b, rsp_v_b, idone_b, rsp_d_b);
        end
        // Requests offered during INIT must be ignored.
        for (int i = 1; i < 32; i++) begin
            rv = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, 31));
            wdata = 8'($urandom);
            step();
            checks++;
            if (rdy !== 1'b0 || idone !== 1'b0 || rsp_v !== 1'b0) begin
                errors++;
                $display("FAIL init_busy cycle %0d: rdy=%b idone=%b rsp_v=%b expected 0 0 0",
                         i, rdy, idone, rsp_v);
            end
            checks++;
            if (rdy_b !== (i >= 20) || idone_b !== (i >= 20)) begin
                errors++;
                $display("FAIL init_b cycle %0d: rdy=%b idone=%b expected %b", i, rdy_b, idone_b, (i >= 20));
            end
        end
        rv = 1'b0; we = 1'b0;
        step();
        checks++;
        if (rdy !== 1'b1 || idone !== 1'b1) begin
            errors++;
            $display("FAIL init_done_edge: rdy=%b idone=%b expected 1 1", rdy, idone);
        end
        model_init_a();
        hold_a = 8'h00;
    endtask

    task automatic test_preset_reads();
        logic [4:0] addrs [4];
        logic [7:0] expv  [4];
        addrs[0] = 5'h1B; addrs[1] = 5'h1C; addrs[2] = 5'h00; addrs[3] = 5'h1F;
        expv[0]  = 8'hFF; expv[1]  = 8'hAA; expv[2]  = 8'h00; expv[3]  = 8'h00;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin rv = 1'b1; we = 1'b0; addr = addrs[k]; end
            else rv = 1'b0;
            step();
            checks++;
            if (k == 0) begin
                if (rsp_v !== 1'b0) begin
                    errors++;
                    $display("FAIL preset_latency: rsp_v=%b expected 0 on accept edge", rsp_v);
                end
            end else if (rsp_v !== 1'b1 || rsp_d !== expv[k-1] || aerr !== 1'b0) begin
                errors++;
                $display("FAIL preset_read addr=%h: rsp_v=%b rdata=%h aerr=%b expected 1 %h 0",
                         addrs[k-1], rsp_v, rsp_d, aerr, expv[k-1]);
            end
        end
        hold_a = 8'h00;
        step();
        checks++;
        if (rsp_v !== 1'b0 || rsp_d !== hold_a) begin
            errors++;
            $display("FAIL preset_hold: rsp_v=%b rdata=%h expected 0 %h", rsp_v, rsp_d, hold_a);
        end
    endtask

    task automatic test_write_read();
        rv = 1'b1; we = 1'b1; addr = 5'h05; wdata = 8'h3C;
        step();
        model[5] = 8'h3C;
        rv = 1'b1; we = 1'b0; addr = 5'h05; wdata = 8'h00;
        step();
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== 8'h3C || aerr !== 1'b0) begin
            errors++;
            $display("FAIL write_echo: rsp_v=%b rdata=%h aerr=%b expected 1 3c 0", rsp_v, rsp_d, aerr);
        end
        rv = 1'b0;
        step();
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== 8'h3C) begin
            errors++;
            $display("FAIL read_after_write: rsp_v=%b rdata=%h expected 1 3c", rsp_v, rsp_d);
        end
        hold_a = 8'h3C;
        step();
        checks++;
        if (rsp_v !== 1'b0 || rsp_d !== hold_a) begin
            errors++;
            $display("FAIL rw_idle: rsp_v=%b rdata=%h expected 0 %h", rsp_v, rsp_d, hold_a);
        end
    endtask

    task automatic test_random();
        bit         pv = 1'b0;
        bit         v;
        logic [7:0] pd = 8'h00;
        for (int k = 0; k < 150; k++) begin
            v = (k < 140) && ($urandom_range(0, 3) != 0);
            rv = v;
            we = 1'($urandom_range(0, 1));
            addr = 5'($urandom_range(0, 31));
            wdata = 8'($urandom);
            #1;
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL random_ready cycle %0d: rdy=%b expected 1", k, rdy);
            end
            step();
            checks++;
            if (pv) begin
                if (rsp_v !== 1'b1 || rsp_d !== pd || aerr !== 1'b0) begin
                    errors++;
                    $display("FAIL random_rsp cycle %0d: rsp_v=%b rdata=%h aerr=%b expected 1 %h 0",
                             k, rsp_v, rsp_d, aerr, pd);
                end
                hold_a = pd;
            end else if (rsp_v !== 1'b0 || rsp_d !== hold_a || aerr !== 1'b0) begin
                errors++;
                $display("FAIL random_idle cycle %0d: rsp_v=%b rdata=%h aerr=%b expected 0 %h 0",
                         k, rsp_v, rsp_d, aerr, hold_a);
            end
            pv = v;
            if (v) begin
                pd = we ? wdata : model[addr];
                if (we) model[addr] = wdata;
            end
        end
        rv = 1'b0;
    endtask

    task automatic test_clear();
        rv = 1'b1; we = 1'b1; addr = 5'h1B; wdata = 8'h12;
        step();
        model[27] = 8'h12;
        clr = 1'b1; rv = 1'b1; we = 1'b1; addr = 5'h05; wdata = 8'h99;
        #1;
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready_drop: rdy=%b expected 0", rdy);
        end
        step();
        clr = 1'b0; rv = 1'b0; we = 1'b0;
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== 8'h12 || idone !== 1'b0 || rdy !== 1'b0) begin
            errors++;
            $display("FAIL clear_edge: rsp_v=%b rdata=%h idone=%b rdy=%b expected 1 12 0 0",
                     rsp_v, rsp_d, idone, rdy);
        end
        hold_a = 8'h12;
        for (int i = 1; i < 32; i++) begin
            step();
            checks++;
            if (rdy !== 1'b0 || idone !== 1'b0 || rsp_v !== 1'b0 || rsp_d !== hold_a) begin
                errors++;
                $display("FAIL clear_init cycle %0d: rdy=%b idone=%b rsp_v=%b rdata=%h expected 0 0 0 %h",
                         i, rdy, idone, rsp_v, rsp_d, hold_a);
            end
        end
        step();
        checks++;
        if (rdy !== 1'b1 || idone !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: rdy=%b idone=%b expected 1 1", rdy, idone);
        end
        model_init_a();
        rv = 1'b1; we = 1'b0; addr = 5'h1B;
        step();
        addr = 5'h05;
        step();
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== model[27]) begin
            errors++;
            $display("FAIL clear_preset: rsp_v=%b rdata=%h expected 1 %h", rsp_v, rsp_d, model[27]);
        end
        rv = 1'b0;
        step();
        checks++;
        if (rsp_v !== 1'b1 || rsp_d !== model[5]) begin
            errors++;
            $display("FAIL clear_refill: rsp_v=%b rdata=%h expected 1 %h", rsp_v, rsp_d, model[5]);
        end
        hold_a = model[5];
    endtask

    task automatic test_reset_mid();
        rv = 1'b1; we = 1'b0; addr = 5'h1C;
        step();
        rv = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rsp_v !== 1'b0 || rsp_d !== 8'h00 || rdy !== 1'b0 || idone !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: rsp_v=%b rdata=%h rdy=%b idone=%b expected 0 00 0 0",
                     rsp_v, rsp_d, rdy, idone);
        end
        hold_a = 8'h00;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i < 32; i++) begin
            step();
            checks++;
            if (rdy !== 1'b0 || rsp_v !== 1'b0) begin
                errors++;
                $display("FAIL restart_init cycle %0d: rdy=%b rsp_v=%b expected 0 0", i, rdy, rsp_v);
            end
        end
        step();
        checks++;
        if (rdy !== 1'b1 || idone !== 1'b1) begin
            errors++;
            $display("FAIL restart_done: rdy=%b idone=%b expected 1 1", rdy, idone);
        end
        // Every location must be back at its init value after the restarted walk.
        model_init_a();
        for (int k = 0; k <= 32; k++) begin
            if (k < 32) begin rv = 1'b1; we = 1'b0; addr = 5'(k); end
            else rv = 1'b0;
            step();
            if (k > 0) begin
                checks++;
                if (rsp_v !== 1'b1 || rsp_d !== model[k-1]) begin
                    errors++;
                    $display("FAIL sweep addr=%0d: rsp_v=%b rdata=%h expected 1 %h",
                             k - 1, rsp_v, rsp_d, model[k-1]);
                end
            end
        end
    endtask

    task automatic test_addr_err();
        logic [4:0] ra  [6];
        logic       rw  [6];
        logic [7:0] rd  [6];
        bit         pv = 1'b0;
        bit         pe = 1'b0;
        logic [7:0] pd = 8'h00;
        for (int i = 0; i < 20; i++) model_b[i] = 8'h00;
        ra[0] = 5'h18; rw[0] = 1'b0; rd[0] = 8'h00;
        ra[1] = 5'h18; rw[1] = 1'b1; rd[1] = 8'h5A;
        ra[2] = 5'h08; rw[2] = 1'b1; rd[2] = 8'hC3;
        ra[3] = 5'h13; rw[3] = 1'b0; rd[3] = 8'h00;
        ra[4] = 5'h14; rw[4] = 1'b1; rd[4] = 8'h77;
        ra[5] = 5'h1F; rw[5] = 1'b0; rd[5] = 8'h00;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin rv_b = 1'b1; we_b = rw[k]; addr_b = ra[k]; wdata_b = rd[k]; end
            else rv_b = 1'b0;
            step();
            if (pv) begin
                checks++;
                if (rsp_v_b !== 1'b1 || rsp_d_b !== pd || aerr_b !== pe) begin
                    errors++;
                    $display("FAIL addr_err_rsp req %0d: rsp_v=%b rdata=%h aerr=%b expected 1 %h %b",
                             k - 1, rsp_v_b, rsp_d_b, aerr_b, pd, pe);
                end
                hold_b = pd;
            end
            pv = (k < 6);
            if (k < 6) begin
                pe = (ra[k] >= 5'd20);
                pd = pe ? 8'h00 : (rw[k] ? rd[k] : model_b[ra[k]]);
                if (rw[k] && !pe) model_b[ra[k]] = rd[k];
            end
        end
        step();
        checks++;
        if (rsp_v_b !== 1'b0 || aerr_b !== 1'b0 || rsp_d_b !== hold_b) begin
            errors++;
            $display("FAIL addr_err_idle: rsp_v=%b aerr=%b rdata=%h expected 0 0 %h",
                     rsp_v_b, aerr_b, rsp_d_b, hold_b);
        end
        // Out-of-range writes must not have aliased onto any real word.
        for (int k = 0; k <= 20; k++) begin
            if (k < 20) begin rv_b = 1'b1; we_b = 1'b0; addr_b = 5'(k); end
            else rv_b = 1'b0;
            step();
            if (k > 0) begin
                checks++;
                if (rsp_v_b !== 1'b1 || rsp_d_b !== model_b[k-1] || aerr_b !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep_b addr=%0d: rsp_v=%b rdata=%h aerr=%b expected 1 %h 0",
                             k - 1, rsp_v_b, rsp_d_b, aerr_b, model_b[k-1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_preset_reads();
        test_write_read();
        test_random();
        test_clear();
        test_reset_mid();
        test_addr_err();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
